// File: rtl/ram_tdp_be_if.sv
// Per-port bus of the true dual-port byte-enable RAM: select, enables, address, data, read valid.
interface ram_tdp_be_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
);
  logic                  cs;
  logic                  oe;
  logic                  we;
  logic [DWIDTH/8-1:0]   be;
  logic [AWIDTH-1:0]     addr;
  logic [DWIDTH-1:0]     din;
  logic [DWIDTH-1:0]     dout;
  logic                  rvalid;

  modport master (output cs, oe, we, be, addr, din, input dout, rvalid);
  modport slave  (input cs, oe, we, be, addr, din, output dout, rvalid);
endinterface

// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte-lane writes, read-first, port-0 lane priority and collision counting.
// Read latency 1; define RAM_TDP_OUTREG_EN for an extra output register stage (latency 2).
module ram_tdp_be #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_tdp_be_if.slave      p0,
  ram_tdp_be_if.slave      p1,
  output logic             coll,
  output logic [7:0]       coll_cnt
);
  localparam int NBYTES = DWIDTH / 8;
  localparam int DEPTH  = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic wr0, wr1, rd0, rd1, coll_hit;
  logic [DWIDTH-1:0] q0, q1, q0_o, q1_o;
  logic v0, v1, v0_o, v1_o;

  assign wr0 = p0.cs & p0.we;
  assign wr1 = p1.cs & p1.we;
  assign rd0 = p0.cs & ~p0.we;
  assign rd1 = p1.cs & ~p1.we;
  assign coll_hit = p0.cs & p1.cs & (p0.addr == p1.addr) & (p0.we | p1.we);

  // Port 0 lane writes are issued last so they override port 1 on a shared lane.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr1 && p1.be[i]) mem[p1.addr][8*i +: 8] <= p1.din[8*i +: 8];
        if (wr0 && p0.be[i]) mem[p0.addr][8*i +: 8] <= p0.din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0 <= '0;
      v0 <= 1'b0;
    end else begin
      v0 <= rd0;
      if (rd0) q0 <= mem[p0.addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd1;
      if (rd1) q1 <= mem[p1.addr];
    end
  end

`ifdef RAM_TDP_OUTREG_EN
  logic [DWIDTH-1:0] q0_s2, q1_s2;
  logic v0_s2, v1_s2;

  // Second stage only reloads on a new read so the held value survives idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0_s2 <= '0;
      q1_s2 <= '0;
      v0_s2 <= 1'b0;
      v1_s2 <= 1'b0;
    end else begin
      v0_s2 <= v0;
      v1_s2 <= v1;
      if (v0) q0_s2 <= q0;
      if (v1) q1_s2 <= q1;
    end
  end

  assign q0_o = q0_s2;
  assign q1_o = q1_s2;
  assign v0_o = v0_s2;
  assign v1_o = v1_s2;
`else
  assign q0_o = q0;
  assign q1_o = q1;
  assign v0_o = v0;
  assign v1_o = v1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll     <= 1'b0;
      coll_cnt <= 8'd0;
    end else begin
      coll <= coll_hit;
      if (coll_hit && coll_cnt != 8'hFF) coll_cnt <= coll_cnt + 8'd1;
    end
  end

  assign p0.dout   = p0.oe ? q0_o : '0;
  assign p1.dout   = p1.oe ? q1_o : '0;
  assign p0.rvalid = v0_o;
  assign p1.rvalid = v1_o;
endmodule

// File: tb/tb_ram_tdp_be.sv
// Directed bench for ram_tdp_be (DWIDTH=16): read results go through per-port scoreboards.
module tb_ram_tdp_be;
`ifdef RAM_TDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coll;
  logic [7:0] coll_cnt;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         exp_cnt;
  exp_t       q0[$];
  exp_t       q1[$];

  ram_tdp_be_if #(.AWIDTH(4), .DWIDTH(16)) b0 ();
  ram_tdp_be_if #(.AWIDTH(4), .DWIDTH(16)) b1 ();

  ram_tdp_be #(.AWIDTH(4), .DWIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0       (b0),
    .p1       (b1),
    .coll     (coll),
    .coll_cnt (coll_cnt)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b0.rvalid === 1'b1) begin
      chk("p0_rvalid_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("p0_rdata", 32'(b0.dout), 32'(e.d));
        chk("p0_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.rvalid === 1'b1) begin
      chk("p1_rvalid_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("p1_rdata", 32'(b1.dout), 32'(e.d));
        chk("p1_latency", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.cs = 1'b0; b0.we = 1'b0; b0.be = 2'b00;
    b1.cs = 1'b0; b1.we = 1'b0; b1.be = 2'b00;
  endtask

  task automatic drv(input int p, input logic we, input logic [1:0] be,
                     input logic [3:0] addr, input logic [15:0] din);
    if (p == 0) begin
      b0.cs = 1'b1; b0.we = we; b0.be = be; b0.addr = addr; b0.din = din;
    end else begin
      b1.cs = 1'b1; b1.we = we; b1.be = be; b1.addr = addr; b1.din = din;
    end
  endtask

  // Issue a read on port p and queue what the port should show when rvalid arrives.
  task automatic rd(input int p, input logic [3:0] addr, input logic [15:0] expd);
    exp_t e;
    drv(p, 1'b0, 2'b00, addr, 16'h0);
    e.due = cyc + LAT;
    if (p == 0) begin
      e.d = b0.oe ? expd : 16'h0;
      q0.push_back(e);
    end else begin
      e.d = b1.oe ? expd : 16'h0;
      q1.push_back(e);
    end
  endtask

  task automatic wr(input int p, input logic [3:0] addr, input logic [15:0] din,
                    input logic [1:0] be);
    drv(p, 1'b1, be, addr, din);
    step();
    idle();
  endtask

  task automatic rd1(input int p, input logic [3:0] addr, input logic [15:0] expd);
    rd(p, addr, expd);
    step();
    idle();
    repeat (LAT) step();
  endtask

  initial begin
    idle();
    b0.oe = 1'b1; b1.oe = 1'b1;
    b0.addr = '0; b1.addr = '0; b0.din = '0; b1.din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid0", 32'(b0.rvalid), 0);
    chk("rst_rvalid1", 32'(b1.rvalid), 0);
    chk("rst_dout0", 32'(b0.dout), 0);
    chk("rst_dout1", 32'(b1.dout), 0);
    chk("rst_coll", 32'(coll), 0);
    chk("rst_coll_cnt", 32'(coll_cnt), 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic write on one port, read on the other.
    wr(0, 4'd3, 16'h00A5, 2'b11);
    rd1(1, 4'd3, 16'h00A5);

    // Upper-lane-only write merges with existing low byte.
    wr(0, 4'd5, 16'h1234, 2'b11);
    wr(0, 4'd5, 16'hABCD, 2'b10);
    rd1(0, 4'd5, 16'hAB34);

    // Write/write collision: port 0 owns lane 0, port 1 gets lane 1.
    drv(0, 1'b1, 2'b01, 4'd7, 16'h1111);
    drv(1, 1'b1, 2'b11, 4'd7, 16'h2222);
    step();
    idle();
    exp_cnt = 1;
    @(negedge clk);
    chk("ww_coll_pulse", 32'(coll), 1);
    chk("ww_coll_cnt", 32'(coll_cnt), 32'(exp_cnt));
    step();
    @(negedge clk);
    chk("ww_coll_drop", 32'(coll), 0);
    rd1(1, 4'd7, 16'h2211);

    // Read-first when the other port writes the same word.
    wr(0, 4'd2, 16'h0055, 2'b11);
    drv(0, 1'b1, 2'b11, 4'd2, 16'h0066);
    rd(1, 4'd2, 16'h0055);
    step();
    idle();
    exp_cnt = 2;
    @(negedge clk);
    chk("rw_coll_pulse", 32'(coll), 1);
    chk("rw_coll_cnt", 32'(coll_cnt), 32'(exp_cnt));
    repeat (LAT) step();
    rd1(1, 4'd2, 16'h0066);

    // Simultaneous writes to different words are not collisions.
    drv(0, 1'b1, 2'b11, 4'd8, 16'hAAAA);
    drv(1, 1'b1, 2'b11, 4'd9, 16'hBBBB);
    step();
    idle();
    @(negedge clk);
    chk("diff_addr_no_coll", 32'(coll), 0);
    rd1(0, 4'd8, 16'hAAAA);
    rd1(1, 4'd9, 16'hBBBB);

    // Deselected ports do nothing.
    b0.cs = 1'b0; b0.we = 1'b1; b0.be = 2'b11; b0.addr = 4'd8; b0.din = 16'hDEAD;
    b1.cs = 1'b0; b1.we = 1'b0; b1.addr = 4'd9;
    step();
    idle();
    repeat (LAT + 1) step();
    rd1(0, 4'd8, 16'hAAAA);

    // Output enable gates dout only; the held value reappears when re-enabled.
    b1.oe = 1'b0;
    rd1(1, 4'd9, 16'hBBBB);
    b1.oe = 1'b1;
    @(negedge clk);
    chk("oe_hold_dout1", 32'(b1.dout), 32'hBBBB);

    // Collision counter saturation.
    for (int i = 0; i < 300; i++) begin
      drv(0, 1'b1, 2'b00, 4'd10, 16'h0);
      drv(1, 1'b1, 2'b00, 4'd10, 16'h0);
      step();
      if (exp_cnt < 255) exp_cnt++;
      @(negedge clk);
      chk("sat_coll_pulse", 32'(coll), 1);
      chk("sat_coll_cnt", 32'(coll_cnt), 32'(exp_cnt));
    end
    idle();
    step();
    @(negedge clk);
    chk("sat_final_cnt", 32'(coll_cnt), 255);
    chk("sat_coll_drop", 32'(coll), 0);

    // Reset during a pending read, plus a write attempted under reset.
    wr(0, 4'd12, 16'h3C3C, 2'b11);
    drv(0, 1'b0, 2'b00, 4'd12, 16'h0);
    drv(1, 1'b1, 2'b11, 4'd3, 16'hFFFF);
    #2;
    rst_n = 1'b0;
    step();
    idle();
    @(negedge clk);
    chk("mid_rst_rvalid0", 32'(b0.rvalid), 0);
    chk("mid_rst_dout0", 32'(b0.dout), 0);
    chk("mid_rst_coll_cnt", 32'(coll_cnt), 0);
    chk("mid_rst_coll", 32'(coll), 0);
    drv(1, 1'b1, 2'b11, 4'd3, 16'hFFFF);
    step();
    idle();
    step();
    rst_n = 1'b1;
    repeat (LAT + 2) step();
    @(negedge clk);
    chk("post_rst_dout0", 32'(b0.dout), 0);
    rd1(0, 4'd12, 16'h3C3C);
    rd1(1, 4'd3, 16'h00A5);
    rd1(0, 4'd7, 16'h2211);

    repeat (LAT + 2) step();
    chk("p0_queue_drained", 32'(q0.size()), 0);
    chk("p1_queue_drained", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_tdp_be.md
RAM_TDP_BE -- requirements
Module: ram_tdp_be

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, address width; depth = 2**AWIDTH words.
REQ-002 SHALL have parameter DWIDTH, default 8, data width; must be a multiple of 8; NBYTES = DWIDTH/8.
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for p in {0,1}: cs_p  input  1  port select.
REQ-006 SHALL have oe_p  input  1  output enable for dout_p.
REQ-007 SHALL have we_p  input  1  write (1) / read (0) when cs_p=1.
REQ-008 SHALL have be_p  input  NBYTES  byte-lane write enables.
REQ-009 SHALL have addr_p  input  AWIDTH  word address.
REQ-010 SHALL have din_p  input  DWIDTH  write data.
REQ-011 SHALL have dout_p  output  DWIDTH  read data.
REQ-012 SHALL have rvalid_p  output  1  one-cycle pulse marking new read data.
REQ-013 SHALL have coll  output  1  one-cycle pulse on a same-address collision.
REQ-014 SHALL have coll_cnt  output  8  saturating collision count.

Function
REQ-015 SHALL perform a write on posedge when cs_p=1, we_p=1, updating only lanes with be_p[i]=1.
REQ-016 SHALL perform a read when cs_p=1, we_p=0; data is registered; latency 1 cycle (base build).
REQ-017 SHALL pulse rvalid_p high for exactly one cycle per read, aligned with the read data.
REQ-018 SHALL drive dout_p = held read register when oe_p=1, else all zeros (no tristate); oe_p acts combinationally.
REQ-019 SHALL hold the read register value until the next read on that port.
REQ-020 SHALL treat a collision as cs_0=cs_1=1, addr_0=addr_1, and we_0|we_1.
REQ-021 SHALL resolve write/write collisions per lane: port 0 wins where be_0[i]=1; port 1 lanes with be_0[i]=0 and be_1[i]=1 are written.
REQ-022 SHALL return old (pre-write) data to a port reading an address written by the other port in the same cycle (read-first).
REQ-023 SHALL pulse coll one cycle after the colliding edge and increment coll_cnt, saturating at 255.
REQ-024 SHALL ignore be_p, din_p, we_p, addr_p when cs_p=0; reads with cs_p=0 produce no rvalid_p.

Reset
REQ-025 SHALL, while rst_n=0, force read registers, rvalid_0, rvalid_1, coll, coll_cnt to 0; dout_p therefore 0.
REQ-026 SHALL not reset memory contents; no write occurs on any edge where rst_n=0.
REQ-027 SHALL discard reads in flight when reset asserts mid-operation; first rvalid_p after release requires a new read.

Configuration
REQ-028 SHALL, with macro RAM_TDP_OUTREG_EN defined, add a second output register stage per port: read latency 2, rvalid_p delayed to match, pipeline reset to 0.
REQ-029 SHALL, without RAM_TDP_OUTREG_EN, have read latency 1 per REQ-016; collision behaviour unchanged in both builds.

Verification
REQ-030 SHALL cover: write 0xA5 port0 addr 3, read port1 addr 3, oe_1=1 -> dout_1=0xA5 with rvalid_1 one cycle later (two with RAM_TDP_OUTREG_EN).
REQ-031 SHALL cover: DWIDTH=16, mem[5]=0x1234, port0 write 0xABCD be_0=2'b10 -> read 0xAB34.
REQ-032 SHALL cover: same edge, port0 writes 0x1111 be=2'b01, port1 writes 0x2222 be=2'b11 to addr 7 -> mem[7]=0x2211, coll=1 next cycle, coll_cnt=1.
REQ-033 SHALL cover: mem[2]=0x55, port0 writes 0x66 while port1 reads addr 2 -> dout_1=0x55, next read returns 0x66.
REQ-034 SHALL cover: 300 collisions -> coll_cnt=255; read with oe=0 -> dout=0 but rvalid pulses.
REQ-035 SHALL cover: rst_n low during pending read -> rvalid, dout, coll_cnt = 0; memory contents retained after release.
